// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an async PWM input in clk cycles.
// Define PWM_CAPTURE_FILTER_EN to insert a FILTER_LEN-cycle glitch filter after the synchronizer.
`timescale 1ns/1ps
module pwm_capture #(
  parameter int unsigned      CNT_W      = 27,
  parameter logic [CNT_W-1:0] TIMEOUT    = 27'd50000000,
  parameter int unsigned      FILTER_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             stuck_hi,
  output logic             stuck_lo,
  output logic             level
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state;
  logic             sync1, sync2, s, prev;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt, hi_lat;

  if (FILTER_LEN < 2) begin : g_bad_filter
    $error("FILTER_LEN must be >= 2");
  end
  if (TIMEOUT < CNT_W'(4)) begin : g_bad_timeout
    $error("TIMEOUT must be >= 4");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int unsigned FW = $clog2(FILTER_LEN);

  logic [FW-1:0] fcnt;
  logic          filt;

  // fcnt counts consecutive cycles the synchronized input disagrees with filt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt <= '0;
      filt <= 1'b0;
    end else if (sync2 == filt) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILTER_LEN - 1)) begin
      fcnt <= '0;
      filt <= sync2;
    end else begin
      fcnt <= fcnt + FW'(1);
    end
  end

  assign s = filt;
`else
  assign s = sync2;
`endif

  assign rise  = s & ~prev;
  assign fall  = ~s & prev;
  assign level = s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prev      <= 1'b0;
      cnt       <= '0;
      hi_lat    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      stuck_hi  <= 1'b0;
      stuck_lo  <= 1'b0;
    end else begin
      valid <= 1'b0;
      prev  <= s;

      if (rise)
        cnt <= CNT_W'(1);
      else if (cnt != TIMEOUT)
        cnt <= cnt + CNT_W'(1);

      // An edge coinciding with saturation is processed normally instead of timing out
      if (!rise && !fall && cnt == TIMEOUT) begin
        state <= IDLE;
        if (s) stuck_hi <= 1'b1;
        else   stuck_lo <= 1'b1;
      end else begin
        case (state)
          IDLE: if (rise) begin
            state    <= HIGH;
            stuck_hi <= 1'b0;
            stuck_lo <= 1'b0;
          end
          HIGH: if (fall) begin
            hi_lat <= cnt;
            state  <= LOW;
          end
          LOW: if (rise) begin
            period    <= cnt;
            high_time <= hi_lat;
            valid     <= 1'b1;
            state     <= HIGH;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus queues expected publishes, a monitor checks each valid.
`timescale 1ns/1ps
module tb_pwm_capture;

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int EXTRA = 4;
  localparam int H1    = 4;
  localparam int GP    = 40;
  localparam int GH    = 20;
`else
  localparam int EXTRA = 0;
  localparam int H1    = 3;
  localparam int GP    = 30;
  localparam int GH    = 10;
`endif

  typedef struct {
    int p;
    int h;
    int c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pwm_in;
  logic [26:0] period, high_time;
  logic        valid, stuck_hi, stuck_lo, level;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];
  exp_t e;

  pwm_capture #(.CNT_W(27), .TIMEOUT(27'd100), .FILTER_LEN(4)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .period(period), .high_time(high_time),
    .valid(valid), .stuck_hi(stuck_hi), .stuck_lo(stuck_lo), .level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PWM cycle; when pub is set, the rise is expected to publish ep/eh
  task automatic pwm(input int h, input int p, input bit pub, input int ep, input int eh);
    pwm_in = 1'b1;
    if (pub) q.push_back('{ep, eh, cyc + 3 + EXTRA});
    drive(1'b1, h);
    drive(1'b0, p - h);
  endtask

  // 40-cycle period, 20 high, with a 2-cycle low glitch inside the high phase
  task automatic glitch(input int ep, input int eh);
    pwm_in = 1'b1;
    q.push_back('{ep, eh, cyc + 3 + EXTRA});
    drive(1'b1, 8);
    drive(1'b0, 2);
`ifndef PWM_CAPTURE_FILTER_EN
    q.push_back('{10, 8, cyc + 3});
`endif
    drive(1'b1, 10);
    drive(1'b0, 20);
  endtask

  always @(negedge clk) begin
    if (valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid period=%0d high=%0d, expected none (cycle %0d)",
                 period, high_time, cyc);
      end else begin
        e = q.pop_front();
        chk("period", int'(period), e.p);
        chk("high_time", int'(high_time), e.h);
        chk("valid_cycle", cyc, e.c);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_period", int'(period), 0);
    chk("rst_high_time", int'(high_time), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_stuck_hi", int'(stuck_hi), 0);
    chk("rst_stuck_lo", int'(stuck_lo), 0);
    chk("rst_level", int'(level), 0);
    rst = 1'b0;

    // stuck low straight after reset
    drive(1'b0, 95);
    chk("stuck_lo_early", int'(stuck_lo), 0);
    drive(1'b0, 10);
    chk("stuck_lo_set", int'(stuck_lo), 1);
    chk("stuck_lo_period", int'(period), 0);
    chk("stuck_lo_high", int'(high_time), 0);
    pwm(5, 10, 1'b0, 0, 0);
    chk("stuck_lo_clear", int'(stuck_lo), 0);

    // clean 5/10 stream
    pwm(5, 10, 1'b1, 10, 5);
    pwm(5, 10, 1'b1, 10, 5);
    chk("level_low", int'(level), 0);

    // duty change
    pwm(H1, 10, 1'b1, 10, 5);
    pwm(H1, 10, 1'b1, 10, H1);
    pwm(7, 20, 1'b1, 10, H1);
    pwm(7, 20, 1'b1, 20, 7);

    // stuck high mid-stream
    pwm_in = 1'b1;
    q.push_back('{20, 7, cyc + 3 + EXTRA});
    drive(1'b1, 150);
    chk("stuck_hi_set", int'(stuck_hi), 1);
    chk("stuck_hi_level", int'(level), 1);
    chk("stuck_hi_period", int'(period), 20);
    chk("stuck_hi_high", int'(high_time), 7);
    drive(1'b0, 10);
    pwm(5, 10, 1'b0, 0, 0);
    chk("stuck_hi_clear", int'(stuck_hi), 0);
    chk("stuck_lo_clear2", int'(stuck_lo), 0);
    pwm(5, 10, 1'b1, 10, 5);

    // period exactly TIMEOUT still publishes
    pwm(50, 100, 1'b1, 10, 5);
    pwm(5, 10, 1'b1, 100, 50);
`ifndef PWM_CAPTURE_FILTER_EN
    // minimum period 2 / high 1
    pwm(1, 2, 1'b1, 10, 5);
    pwm(1, 2, 1'b1, 2, 1);
    pwm(5, 10, 1'b1, 2, 1);
`endif

    // period of TIMEOUT+1 times out: no publish on the following rise
    pwm(50, 101, 1'b1, 10, 5);
    drive(1'b0, 5);
    chk("timeout101_stuck_lo", int'(stuck_lo), 1);
    pwm(5, 10, 1'b0, 0, 0);
    pwm(5, 10, 1'b1, 10, 5);

    // asynchronous reset during a high phase
    pwm_in = 1'b1;
    q.push_back('{10, 5, cyc + 3 + EXTRA});
    drive(1'b1, 4 + EXTRA);
    #1 rst = 1'b1;
    #1;
    chk("midrst_period", int'(period), 0);
    chk("midrst_high", int'(high_time), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_level", int'(level), 0);
    chk("midrst_stuck", int'({stuck_hi, stuck_lo}), 0);
    drive(1'b0, 3);
    rst = 1'b0;
    drive(1'b0, 10);
    pwm(5, 10, 1'b0, 0, 0);
    pwm(5, 10, 1'b1, 10, 5);

    // glitchy 40/20 stream
    glitch(10, 5);
    glitch(GP, GH);
    glitch(GP, GH);
    pwm(5, 10, 1'b1, GP, GH);
    drive(1'b0, 20);

    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
